// File: rtl/pipeif_pkg.sv
// Shared encodings for the prefetching instruction-fetch stage: pcsource codes,
// the NOP word driven when no instruction is presented, and the fetch FSM states.
package pipeif_pkg;

  localparam logic [1:0] PCS_SEQ = 2'b00;
  localparam logic [1:0] PCS_BR  = 2'b01;
  localparam logic [1:0] PCS_JR  = 2'b10;
  localparam logic [1:0] PCS_J   = 2'b11;

  localparam logic [31:0] NOP_WORD = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'b00,
    ST_FETCH = 2'b01,
    ST_HOLD  = 2'b10
  } fetch_state_e;

endpackage

// File: rtl/pipeif_fifo.sv
// Synchronous FIFO for the prefetch queue; power-of-2 depth, pointers carry one
// extra wrap bit so full and empty are distinguished without a separate flag.
module pipeif_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     clear,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wp;
  logic [AW:0]      rp;

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push) wp <= wp + (AW+1)'(1);
      if (pop)  rp <= rp + (AW+1)'(1);
    end
  end

  // Storage is data only; validity is tracked entirely by the pointers.
  always_ff @(posedge clock) begin
    if (push) mem[wp[AW-1:0]] <= wdata;
  end

  assign rdata = mem[rp[AW-1:0]];
  assign count = wp - rp;
  assign empty = (wp == rp);
  assign full  = (count == (AW+1)'(DEPTH));

endmodule

// File: rtl/pipeif_prefetch.sv
// Instruction-fetch stage with prefetch queue between the IROM and IF/ID register.
// Optional redirect counter port enabled by defining PIPEIF_REDIRECT_CNT_EN.
module pipeif_prefetch
  import pipeif_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter int              IROM_AW  = 6,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [1:0]         pcsource,
  input  logic [XLEN-1:0]    bpc,
  input  logic [XLEN-1:0]    da,
  input  logic [XLEN-1:0]    jpc,
  input  logic               stall,
  input  logic               dbubble,
  output logic [IROM_AW-1:0] irom_addr,
  output logic               irom_rd,
  input  logic [XLEN-1:0]    irom_data,
  output logic               ins_valid,
  output logic [XLEN-1:0]    ins,
  output logic [XLEN-1:0]    pc4
`ifdef PIPEIF_REDIRECT_CNT_EN
  ,
  output logic [15:0]        redirect_cnt
`endif
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic              redirect;
  logic              issue;
  logic              push;
  logic              pop;
  logic              full;
  logic              empty;
  logic              inflight;
  logic [CW-1:0]     count;
  logic [CW-1:0]     level;
  logic [XLEN-1:0]   fpc;
  logic [XLEN-1:0]   tag;
  logic [XLEN-1:0]   target;
  logic [2*XLEN-1:0] head;
  fetch_state_e      state;
  fetch_state_e      state_next;

  assign redirect = (pcsource != PCS_SEQ);

  always_comb begin
    target = bpc;
    case (pcsource)
      PCS_BR:  target = bpc;
      PCS_JR:  target = da;
      PCS_J:   target = jpc;
      default: target = bpc;
    endcase
  end

  // Queued words plus the outstanding read reserve queue slots before issuing.
  assign level   = count + CW'(inflight);
  assign issue   = !reset && !redirect && (level < CW'(DEPTH));
  assign push    = inflight && !redirect && !reset;
  assign pop     = ins_valid && !stall && !redirect && !reset;

  assign irom_rd   = issue;
  assign irom_addr = fpc[IROM_AW+1:2];

  assign ins_valid = !empty && !dbubble;
  assign ins       = ins_valid ? head[2*XLEN-1:XLEN] : XLEN'(NOP_WORD);
  assign pc4       = ins_valid ? head[XLEN-1:0] : '0;

  pipeif_fifo #(
    .WIDTH (2*XLEN),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock (clock),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .clear (redirect),
    .wdata ({irom_data, tag}),
    .rdata (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      fpc      <= RESET_PC;
      inflight <= 1'b0;
    end else if (redirect) begin
      fpc      <= target;
      inflight <= 1'b0;
    end else begin
      inflight <= issue;
      if (issue) fpc <= fpc + XLEN'(4);
    end
  end

  always_ff @(posedge clock) begin
    if (issue) tag <= fpc + XLEN'(4);
  end

  always_ff @(posedge clock) begin
    if (!reset) assert (!(push && full));
  end

  always_ff @(posedge clock) begin
    if (reset) state <= ST_BOOT;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_BOOT:  state_next = ST_FETCH;
      ST_FETCH: if (!redirect && level == CW'(DEPTH)) state_next = ST_HOLD;
      ST_HOLD:  if (pop || redirect) state_next = ST_FETCH;
      default:  state_next = ST_BOOT;
    endcase
  end

`ifdef PIPEIF_REDIRECT_CNT_EN
  always_ff @(posedge clock) begin
    if (reset) redirect_cnt <= '0;
    else if (redirect && redirect_cnt != 16'hFFFF) redirect_cnt <= redirect_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_pipeif_prefetch.sv
// Bench for pipeif_prefetch: constant vector table, directed corner sequences and
// random stimulus against a queue-based reference model of the fetch stage.
module tb_pipeif_prefetch;

  logic        clock = 1'b0;
  logic        reset;
  logic [1:0]  pcsource;
  logic [31:0] bpc, da, jpc;
  logic        stall, dbubble;
  logic [5:0]  irom_addr;
  logic        irom_rd;
  logic [31:0] irom_data;
  logic        ins_valid;
  logic [31:0] ins, pc4;
`ifdef PIPEIF_REDIRECT_CNT_EN
  logic [15:0] redirect_cnt;
`endif

  int n_chk = 0;
  int n_err = 0;

  logic [31:0] rom [64];

  // reference model state
  logic [31:0] m_fpc;
  logic [63:0] m_q [$];
  bit          m_pend;
  logic [63:0] m_pword;

  typedef struct {
    logic        rst;
    logic        stl;
    logic        e_v;
    logic [31:0] e_ins;
    logic [31:0] e_pc4;
    logic        e_rd;
  } vec_t;

  vec_t vt [17];

  pipeif_prefetch dut (
    .clock     (clock),
    .reset     (reset),
    .pcsource  (pcsource),
    .bpc       (bpc),
    .da        (da),
    .jpc       (jpc),
    .stall     (stall),
    .dbubble   (dbubble),
    .irom_addr (irom_addr),
    .irom_rd   (irom_rd),
    .irom_data (irom_data),
    .ins_valid (ins_valid),
    .ins       (ins),
    .pc4       (pc4)
`ifdef PIPEIF_REDIRECT_CNT_EN
    ,
    .redirect_cnt (redirect_cnt)
`endif
  );

  always #5 clock = ~clock;

  always @(posedge clock) irom_data <= rom[irom_addr];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic check_model();
    logic        exp_rd, exp_v;
    logic [31:0] exp_ins, exp_pc4;
    #1;
    exp_rd  = !reset && (pcsource == 2'b00) && ((m_q.size() + int'(m_pend)) < 4);
    exp_v   = (m_q.size() != 0) && !dbubble;
    exp_ins = exp_v ? m_q[0][63:32] : 32'h0;
    exp_pc4 = exp_v ? m_q[0][31:0]  : 32'h0;
    chk("m_irom_rd", {31'h0, irom_rd}, {31'h0, exp_rd});
    if (exp_rd) chk("m_irom_addr", {26'h0, irom_addr}, {26'h0, m_fpc[7:2]});
    chk("m_ins_valid", {31'h0, ins_valid}, {31'h0, exp_v});
    chk("m_ins", ins, exp_ins);
    chk("m_pc4", pc4, exp_pc4);
  endtask

  task automatic advance();
    logic [31:0] tgt;
    bit          valid, iss;
    tgt = (pcsource == 2'b01) ? bpc : (pcsource == 2'b10) ? da : jpc;
    if (reset) begin
      m_fpc = 32'h0; m_q.delete(); m_pend = 0;
    end else if (pcsource != 2'b00) begin
      m_fpc = tgt; m_q.delete(); m_pend = 0;
    end else begin
      valid = (m_q.size() != 0) && !dbubble;
      iss   = (m_q.size() + int'(m_pend)) < 4;
      if (valid && !stall) void'(m_q.pop_front());
      if (m_pend) m_q.push_back(m_pword);
      m_pend = iss;
      if (iss) begin
        m_pword = {rom[m_fpc[7:2]], m_fpc + 32'd4};
        m_fpc   = m_fpc + 32'd4;
      end
    end
    @(negedge clock);
  endtask

  task automatic cycle();
    check_model();
    advance();
  endtask

  task automatic drive(input logic r, input logic [1:0] pcs, input logic s, input logic db);
    reset = r; pcsource = pcs; stall = s; dbubble = db;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 64; i++) rom[i] = i + 1;
    m_fpc = 32'h0; m_pend = 0; m_pword = '0;
    bpc = 32'h0; da = 32'h0; jpc = 32'h0;
    drive(1'b1, 2'b00, 1'b0, 1'b0);

    //                rst stl v  ins   pc4    rd
    vt[0]  = '{1'b1, 1'b0, 1'b0, 32'd0, 32'd0,  1'b0};
    vt[1]  = '{1'b0, 1'b0, 1'b0, 32'd0, 32'd0,  1'b1};
    vt[2]  = '{1'b0, 1'b0, 1'b0, 32'd0, 32'd0,  1'b1};
    vt[3]  = '{1'b0, 1'b0, 1'b1, 32'd1, 32'd4,  1'b1};
    vt[4]  = '{1'b0, 1'b0, 1'b1, 32'd2, 32'd8,  1'b1};
    vt[5]  = '{1'b0, 1'b0, 1'b1, 32'd3, 32'd12, 1'b1};
    vt[6]  = '{1'b0, 1'b1, 1'b1, 32'd4, 32'd16, 1'b1};
    vt[7]  = '{1'b0, 1'b1, 1'b1, 32'd4, 32'd16, 1'b1};
    vt[8]  = '{1'b0, 1'b1, 1'b1, 32'd4, 32'd16, 1'b0};
    vt[9]  = '{1'b0, 1'b1, 1'b1, 32'd4, 32'd16, 1'b0};
    vt[10] = '{1'b0, 1'b1, 1'b1, 32'd4, 32'd16, 1'b0};
    vt[11] = '{1'b0, 1'b1, 1'b1, 32'd4, 32'd16, 1'b0};
    vt[12] = '{1'b0, 1'b0, 1'b1, 32'd4, 32'd16, 1'b0};
    vt[13] = '{1'b0, 1'b0, 1'b1, 32'd5, 32'd20, 1'b1};
    vt[14] = '{1'b0, 1'b0, 1'b1, 32'd6, 32'd24, 1'b1};
    vt[15] = '{1'b0, 1'b0, 1'b1, 32'd7, 32'd28, 1'b1};
    vt[16] = '{1'b0, 1'b0, 1'b1, 32'd8, 32'd32, 1'b1};

    @(negedge clock);

    // reset, sequential stream, stall until full, release
    for (int i = 0; i < 17; i++) begin
      drive(vt[i].rst, 2'b00, vt[i].stl, 1'b0);
      check_model();
      chk($sformatf("t_row%0d_valid", i), {31'h0, ins_valid}, {31'h0, vt[i].e_v});
      chk($sformatf("t_row%0d_ins", i), ins, vt[i].e_ins);
      chk($sformatf("t_row%0d_pc4", i), pc4, vt[i].e_pc4);
      chk($sformatf("t_row%0d_rd", i), {31'h0, irom_rd}, {31'h0, vt[i].e_rd});
      advance();
    end

    // branch redirect with three words queued and one read in flight
    drive(1'b1, 2'b00, 1'b0, 1'b0);
    cycle();
    drive(1'b0, 2'b00, 1'b1, 1'b0);
    for (int i = 0; i < 20 && m_q.size() != 3; i++) cycle();
    bpc = 32'h40;
    drive(1'b0, 2'b01, 1'b1, 1'b0);
    cycle();
    drive(1'b0, 2'b00, 1'b0, 1'b0);
    check_model();
    chk("t3_valid_k0", {31'h0, ins_valid}, 32'h0);
    chk("t3_addr_k0", {26'h0, irom_addr}, 32'd16);
    advance();
    check_model();
    chk("t3_valid_k1", {31'h0, ins_valid}, 32'h0);
    advance();
    check_model();
    chk("t3_valid_k2", {31'h0, ins_valid}, 32'h1);
    chk("t3_ins_k2", ins, 32'd17);
    chk("t3_pc4_k2", pc4, 32'h44);
    advance();

    // bubble holds the head, which is popped the following cycle
    drive(1'b0, 2'b00, 1'b0, 1'b1);
    check_model();
    chk("t4_bubble_valid", {31'h0, ins_valid}, 32'h0);
    chk("t4_bubble_ins", ins, 32'h0);
    chk("t4_bubble_pc4", pc4, 32'h0);
    advance();
    drive(1'b0, 2'b00, 1'b0, 1'b0);
    check_model();
    chk("t4_head_ins", ins, 32'd18);
    chk("t4_head_pc4", pc4, 32'h48);
    advance();

    // reset wins over a simultaneous jump; then jump to the top of the address space
    jpc = 32'h0000_1234;
    drive(1'b1, 2'b11, 1'b0, 1'b0);
    cycle();
    drive(1'b0, 2'b00, 1'b0, 1'b0);
    check_model();
    chk("t5_reset_addr", {26'h0, irom_addr}, 32'd0);
    chk("t5_reset_valid", {31'h0, ins_valid}, 32'h0);
    advance();
    jpc = 32'hFFFF_FFFC;
    drive(1'b0, 2'b11, 1'b0, 1'b0);
    cycle();
    drive(1'b0, 2'b00, 1'b0, 1'b0);
    check_model();
    chk("t5_wrap_addr_hi", {26'h0, irom_addr}, 32'd63);
    advance();
    check_model();
    chk("t5_wrap_addr_lo", {26'h0, irom_addr}, 32'd0);
    advance();
    check_model();
    chk("t5_wrap_ins", ins, 32'd64);
    chk("t5_wrap_pc4", pc4, 32'h0);
    chk("t5_wrap_valid", {31'h0, ins_valid}, 32'h1);
    advance();

`ifdef PIPEIF_REDIRECT_CNT_EN
    drive(1'b1, 2'b00, 1'b0, 1'b0);
    cycle();
    bpc = 32'h10; da = 32'h20; jpc = 32'h30;
    drive(1'b0, 2'b01, 1'b0, 1'b0); cycle();
    drive(1'b0, 2'b10, 1'b0, 1'b0); cycle();
    drive(1'b0, 2'b11, 1'b0, 1'b0); cycle();
    drive(1'b0, 2'b00, 1'b0, 1'b0);
    #1;
    chk("t6_cnt_three", {16'h0, redirect_cnt}, 32'd3);
    drive(1'b1, 2'b00, 1'b0, 1'b0);
    cycle();
    drive(1'b0, 2'b00, 1'b0, 1'b0);
    #1;
    chk("t6_cnt_reset", {16'h0, redirect_cnt}, 32'd0);
    cycle();
`endif

    // random traffic against the reference model
    for (int i = 0; i < 400; i++) begin
      bpc = $urandom & 32'hFFFF_FFFC;
      da  = $urandom & 32'hFFFF_FFFC;
      jpc = $urandom & 32'hFFFF_FFFC;
      drive(($urandom_range(0, 63) == 0),
            ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 3)) : 2'b00,
            ($urandom_range(0, 2) == 0),
            ($urandom_range(0, 7) == 0));
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
